// File: rtl/conv_para_scale_ctrl.sv
// Tile sequencer for one ConvParaScaleFloat16 unit: walks the kernel
// window, brackets the unit's reset around accumulation, hands off the tile.
module conv_para_scale_ctrl #(
    parameter int DATA_WIDTH        = 16,
    parameter int PARA_X            = 3,
    parameter int PARA_Y            = 3,
    parameter int KERNEL_SIZE_WIDTH = 4,
    parameter int WEIGHT_ADDR_WIDTH = 8
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic [KERNEL_SIZE_WIDTH-1:0]        kernel_size_in,
    input  logic [WEIGHT_ADDR_WIDTH-1:0]        weight_base,
    output logic                                busy,
    output logic                                err,
    output logic                                fm_valid,
    output logic [KERNEL_SIZE_WIDTH-1:0]        fm_kx,
    output logic [KERNEL_SIZE_WIDTH-1:0]        fm_ky,
    output logic [1:0]                          fm_mode,
    output logic                                weight_rd_en,
    output logic [WEIGHT_ADDR_WIDTH-1:0]        weight_addr,
    output logic                                conv_rst,
    output logic [KERNEL_SIZE_WIDTH-1:0]        conv_kernel_size,
    input  logic                                conv_result_ready,
    input  logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] conv_result_buffer,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [PARA_X*PARA_Y*DATA_WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, OUT} state_t;

    localparam logic [1:0] MODE_FULL = 2'b00;
    localparam logic [1:0] MODE_ROW  = 2'b01;
    localparam logic [1:0] MODE_COL  = 2'b10;
    localparam logic [1:0] MODE_ONE  = 2'b11;

    state_t                       state;
    logic [KERNEL_SIZE_WIDTH-1:0] k_last;
    logic [KERNEL_SIZE_WIDTH-1:0] nkx;
    logic [KERNEL_SIZE_WIDTH-1:0] nky;
    logic [1:0]                   nmode;
    logic                         row_end;
    logic                         last_step;

    // Next-step window position; step 0 is never produced here.
    always_comb begin
        k_last    = conv_kernel_size - 1'b1;
        row_end   = (fm_kx == k_last);
        last_step = row_end && (fm_ky == k_last);
        nkx       = row_end ? '0 : fm_kx + 1'b1;
        nky       = row_end ? fm_ky + 1'b1 : fm_ky;
        if (nky == '0)
            nmode = MODE_ROW;
        else if (nkx == '0)
            nmode = MODE_COL;
        else
            nmode = MODE_ONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state            <= IDLE;
            busy             <= 1'b0;
            err              <= 1'b0;
            fm_valid         <= 1'b0;
            fm_kx            <= '0;
            fm_ky            <= '0;
            fm_mode          <= MODE_FULL;
            weight_rd_en     <= 1'b0;
            weight_addr      <= '0;
            conv_rst         <= 1'b0;
            conv_kernel_size <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (kernel_size_in == '0) begin
                            err <= 1'b1;
                        end else begin
                            conv_kernel_size <= kernel_size_in;
                            weight_addr      <= weight_base;
                            fm_kx            <= '0;
                            fm_ky            <= '0;
                            fm_mode          <= MODE_FULL;
                            fm_valid         <= 1'b1;
                            weight_rd_en     <= 1'b1;
                            busy             <= 1'b1;
                            state            <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    // Step 0 data reaches the unit now; release it.
                    conv_rst <= 1'b1;
                    if (last_step) begin
                        fm_valid     <= 1'b0;
                        weight_rd_en <= 1'b0;
                        state        <= DRAIN;
                    end else begin
                        fm_kx       <= nkx;
                        fm_ky       <= nky;
                        fm_mode     <= nmode;
                        weight_addr <= weight_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (conv_result_ready) begin
                        out_data  <= conv_result_buffer;
                        conv_rst  <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_para_scale_ctrl.sv
// Directed bench for conv_para_scale_ctrl: step sequence, drain, handshake,
// rejected starts and mid-job reset.
module tb_conv_para_scale_ctrl;

    localparam int DW = 16;
    localparam int PX = 3;
    localparam int PY = 3;
    localparam int KW = 4;
    localparam int AW = 8;
    localparam int OW = PX * PY * DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [KW-1:0] kernel_size_in;
    logic [AW-1:0] weight_base;
    logic          busy;
    logic          err;
    logic          fm_valid;
    logic [KW-1:0] fm_kx;
    logic [KW-1:0] fm_ky;
    logic [1:0]    fm_mode;
    logic          weight_rd_en;
    logic [AW-1:0] weight_addr;
    logic          conv_rst;
    logic [KW-1:0] conv_kernel_size;
    logic          conv_result_ready;
    logic [OW-1:0] conv_result_buffer;
    logic          out_valid;
    logic          out_ready;
    logic [OW-1:0] out_data;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    conv_para_scale_ctrl #(
        .DATA_WIDTH(DW),
        .PARA_X(PX),
        .PARA_Y(PY),
        .KERNEL_SIZE_WIDTH(KW),
        .WEIGHT_ADDR_WIDTH(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .kernel_size_in(kernel_size_in),
        .weight_base(weight_base),
        .busy(busy),
        .err(err),
        .fm_valid(fm_valid),
        .fm_kx(fm_kx),
        .fm_ky(fm_ky),
        .fm_mode(fm_mode),
        .weight_rd_en(weight_rd_en),
        .weight_addr(weight_addr),
        .conv_rst(conv_rst),
        .conv_kernel_size(conv_kernel_size),
        .conv_result_ready(conv_result_ready),
        .conv_result_buffer(conv_result_buffer),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data)
    );

    // {busy, err, fm_valid, weight_rd_en, conv_rst, out_valid}
    logic [5:0]   ctl;
    logic [27:0]  stp;
    logic [171:0] all_o;

    assign ctl = {busy, err, fm_valid, weight_rd_en, conv_rst, out_valid};
    assign stp = {busy, err, fm_valid, weight_rd_en, fm_kx, fm_ky,
                  fm_mode, weight_addr, conv_rst, out_valid,
                  conv_kernel_size};
    assign all_o = {busy, err, fm_valid, fm_kx, fm_ky, fm_mode,
                    weight_rd_en, weight_addr, conv_rst,
                    conv_kernel_size, out_valid, out_data};

    task automatic chk(input string tag,
                       input logic [191:0] got,
                       input logic [191:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_step(input int k, input logic [7:0] base,
                              input int n);
        logic [3:0] ekx;
        logic [3:0] eky;
        logic [3:0] kk;
        logic [1:0] em;
        logic [7:0] ea;
        logic       ecr;
        ekx = 4'(n % k);
        eky = 4'(n / k);
        kk  = 4'(k);
        ea  = base + 8'(n);
        ecr = (n != 0);
        if (n == 0)
            em = 2'd0;
        else if (eky == 4'd0)
            em = 2'd1;
        else if (ekx == 4'd0)
            em = 2'd2;
        else
            em = 2'd3;
        chk($sformatf("step%0d_k%0d", n, k), 192'(stp),
            192'({1'b1, 1'b0, 1'b1, 1'b1, ekx, eky, em, ea,
                  ecr, 1'b0, kk}));
    endtask

    // Called at a negedge; returns at the negedge after the handshake,
    // so a following call issues start for edge H+1.
    task automatic run_job(input int k, input logic [7:0] base,
                           input int dly, input int hold,
                           input logic [OW-1:0] res);
        start = 1'b1;
        kernel_size_in = 4'(k);
        weight_base = base;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < k * k; n++) begin
            check_step(k, base, n);
            conv_result_ready = (n == 1);
            start = (n == 2);
            kernel_size_in = (n == 2) ? 4'd0 : 4'(k);
            @(negedge clk);
        end
        start = 1'b0;
        conv_result_ready = 1'b0;
        kernel_size_in = 4'(k);
        for (int i = 0; i < dly; i++) begin
            chk("drain", 192'(ctl), 192'(6'b100010));
            @(negedge clk);
        end
        conv_result_buffer = res;
        conv_result_ready = 1'b1;
        @(negedge clk);
        conv_result_ready = 1'b0;
        conv_result_buffer = '0;
        for (int i = 0; i < hold; i++) begin
            chk("out_hold_ctl", 192'(ctl), 192'(6'b100001));
            chk("out_hold_data", 192'(out_data), 192'(res));
            start = (i == 1);
            @(negedge clk);
        end
        start = 1'b0;
        chk("out_ctl", 192'(ctl), 192'(6'b100001));
        chk("out_data", 192'(out_data), 192'(res));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("after_hs", 192'(ctl), 192'(6'b000000));
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        kernel_size_in = '0;
        weight_base = '0;
        conv_result_ready = 1'b0;
        conv_result_buffer = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset", 192'(all_o), 192'(0));
        rst = 1'b1;
        @(negedge clk);

        run_job(3, 8'h10, 4, 6,
                {9{16'h3c00}} ^ 144'h0123_4567_89ab_cdef_1357);
        run_job(5, 8'hFE, 2, 0,
                144'hdead_beef_cafe_f00d_1111_2222_3333_4444_5555);
        run_job(1, 8'h40, 1, 1,
                144'h8000_7bff_0001_3555_c000_4000_bc00_3c00_0000);

        start = 1'b1;
        kernel_size_in = 4'd0;
        weight_base = 8'h33;
        @(negedge clk);
        start = 1'b0;
        chk("err_pulse", 192'(ctl), 192'(6'b010000));
        @(negedge clk);
        chk("err_clear", 192'(ctl), 192'(6'b000000));

        start = 1'b1;
        kernel_size_in = 4'd3;
        weight_base = 8'h20;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 5; n++) begin
            check_step(3, 8'h20, n);
            if (n < 4) @(negedge clk);
        end
        rst = 1'b0;
        #1;
        chk("abort", 192'(all_o), 192'(0));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("post_abort", 192'(ctl), 192'(6'b000000));
        run_job(3, 8'h20, 2, 2,
                144'h1234_5678_9abc_def0_0fed_cba9_8765_4321_aaaa);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_para_scale_ctrl.md
# conv_para_scale_ctrl

Sequencer that drives one ConvParaScaleFloat16 parallel convolution unit for a single output tile. On `start`, it walks the kernel window, issuing one feature-map fetch descriptor and one weight-RAM read per cycle. It holds the unit's active-low `rst` released while the unit accumulates, then captures `result_buffer` when `result_ready` rises and presents the tile downstream on a valid/ready handshake. It sits between the tile scheduler and the feature-map/weight buffers on one side and the conv unit on the other.

## Interface
- `DATA_WIDTH`, 16, float16 element width
- `PARA_X`, 3, tile width in outputs
- `PARA_Y`, 3, tile height in outputs
- `KERNEL_SIZE_WIDTH`, 4, width of kernel-size fields
- `WEIGHT_ADDR_WIDTH`, 8, weight RAM address width

- `clk`  in  1  clock
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  one-cycle job request; sampled only in IDLE
- `kernel_size_in`  in  KERNEL_SIZE_WIDTH  K, latched at start
- `weight_base`  in  WEIGHT_ADDR_WIDTH  first weight address, latched at start
- `busy`  out  1  high from start acceptance until output handshake
- `err`  out  1  one-cycle pulse: start rejected because K==0
- `fm_valid`  out  1  fetch descriptor valid (feature-map buffer returns data next cycle)
- `fm_kx`, `fm_ky`  out  KERNEL_SIZE_WIDTH each  kernel column/row of the current step
- `fm_mode`  out  2  00 FULL (PARA_X*PARA_Y elems), 01 ROW (PARA_X elems), 10 COL (PARA_Y elems), 11 ONE (1 elem)
- `weight_rd_en`  out  1  weight RAM read enable (1-cycle read latency)
- `weight_addr`  out  WEIGHT_ADDR_WIDTH  weight RAM address
- `conv_rst`  out  1  to conv unit `rst`; 0 holds unit in reset
- `conv_kernel_size`  out  KERNEL_SIZE_WIDTH  latched K, to conv unit
- `conv_result_ready`  in  1  conv unit `result_ready`
- `conv_result_buffer`  in  PARA_X*PARA_Y*DATA_WIDTH  conv unit `result_buffer`
- `out_valid`  out  1  tile result valid
- `out_ready`  in  1  downstream accept
- `out_data`  out  PARA_X*PARA_Y*DATA_WIDTH  captured tile result

## Operation
- States: IDLE, ISSUE, DRAIN, OUT.
- IDLE: with `start`=1 and K≥1, latch K and `weight_base`, clear kx=ky=0, set `busy`, and go to ISSUE. With `start`=1 and K==0, pulse `err` and stay in IDLE.
- ISSUE: one step per cycle, K*K steps in row-major order (kx fastest).
  - `fm_valid`=`weight_rd_en`=1.
  - `weight_addr` = base + step index, wrapping modulo 2^WEIGHT_ADDR_WIDTH.
  - Mode per step: step 0 FULL; ky==0 with kx>0 ROW; ky>0 with kx==0 COL; otherwise ONE.
  - After step K*K-1, go to DRAIN.
- DRAIN: wait for `conv_result_ready`=1. At that edge, capture `conv_result_buffer` into `out_data`, drive `conv_rst`=0, go to OUT.
- OUT: `out_valid`=1, `out_data` stable. On `out_valid`&&`out_ready`, drop `busy` and return to IDLE.
- `conv_rst` is 1 only from the cycle after step 0 is issued (first data arrives at the conv unit) until the capture edge. At all other times it is 0, so the unit is held clear whenever idle.
- `start` outside IDLE is ignored, with no error.
- `conv_result_ready` outside DRAIN is ignored.
- K==1: a single FULL step, then DRAIN.
- `rst` low at any time, including mid-ISSUE or mid-DRAIN: immediately return to IDLE and drive all outputs to reset values. Partial job is discarded.

## Timing
- Reset values: `busy`, `err`, `fm_valid`, `weight_rd_en`, `out_valid`, `conv_rst` all 0; `fm_kx`, `fm_ky`, `fm_mode`, `weight_addr`, `conv_kernel_size`, `out_data` all 0.
- All outputs are registered.
- `start` sampled at edge S: `busy`=1 from S+1; step n issued in cycle S+1+n.
- `conv_rst` rises in cycle S+2.
- Last step in cycle S+K*K; DRAIN from S+K*K+1.
- `conv_result_ready` seen at edge R: `out_valid` and `conv_rst`=0 from R+1.
- Handshake at edge H: `out_valid`=0 and `busy`=0 from H+1. The earliest next accepted `start` is sampled at edge H+1.

## Test plan
- K=3, base=0x10, `conv_result_ready` raised 4 cycles after last step -> modes FULL,ROW,ROW,COL,ONE,ONE,COL,ONE,ONE; addrs 0x10..0x18; `conv_rst` high from S+2 to capture; `out_data` equals the injected result buffer.
- K=5, base=0xFE -> 25 steps; addr wraps 0xFE,0xFF,0x00…0x16; COL at steps 5,10,15,20.
- K=1 -> one FULL step at addr=base, then DRAIN; K=0 -> `err` pulse, `busy` stays 0.
- `out_ready` held 0 for 6 cycles -> `out_valid`/`out_data` stable; `start` pulses during ISSUE/OUT ignored; after the handshake, a new start at H+1 is accepted.
- `rst` low during step 4 of K=3 -> all outputs 0 immediately (`conv_rst`=0); after release, a fresh job runs from step 0.
